// File: rtl/sprite_anim_if.sv
// Handshake bundle between the movement logic and one sprite animation sequencer.
// The master drives the per-frame movement state. The slave returns the sprite select word.
interface sprite_anim_if;
    logic       frame_tick;
    logic       move_left;
    logic       move_right;
    logic       airborne;
    logic [6:0] sprite_control;
    logic       anim_step;

    modport master (
        output frame_tick, move_left, move_right, airborne,
        input  sprite_control, anim_step
    );

    modport slave (
        input  frame_tick, move_left, move_right, airborne,
        output sprite_control, anim_step
    );
endinterface

// File: rtl/sprite_anim_ctl.sv
// Sprite pose sequencer: IDLE/RUN/JUMP state plus run-cycle counters. State advances only on frame_tick.
// The registered output changes only at frame boundaries, so a single frame never mixes two poses.
module sprite_anim_ctl #(
    parameter int FRAMES_PER_STEP = 4,
    parameter int RUN_FRAMES      = 8,
    parameter int IDLE_DELAY      = 2
) (
    input  logic         clk,
    input  logic         rst,
    sprite_anim_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_JUMP} state_t;

    typedef struct packed {
        state_t     state;
        logic       dir;
        logic [2:0] frame;
        logic [7:0] step;
        logic [7:0] still;
    } ctx_t;

    localparam ctx_t       CTX_RST    = '{state: ST_IDLE, dir: 1'b1, frame: 3'd0,
                                          step: 8'd0, still: 8'd0};
    localparam logic [7:0] STEP_LAST  = 8'(FRAMES_PER_STEP - 1);
    localparam logic [7:0] STILL_LAST = 8'(IDLE_DELAY - 1);
    localparam logic [2:0] FRAME_LAST = 3'(RUN_FRAMES - 1);
    localparam logic [6:0] SPR_RST    = 7'h50;

    ctx_t       ctx, ctx_n;
    logic       moving;
    logic [6:0] spr_n, spr_q;
    logic       step_q;

    assign moving = bus.move_left ^ bus.move_right;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 ctx <= CTX_RST;
        else if (bus.frame_tick) ctx <= ctx_n;
    end

    always_comb begin
        ctx_n = ctx;
        if (moving) ctx_n.dir = bus.move_right;
        if (bus.airborne) begin
            ctx_n.state = ST_JUMP;
            ctx_n.frame = 3'd0;
            ctx_n.step  = 8'd0;
            ctx_n.still = 8'd0;
        end else begin
            unique case (ctx.state)
                ST_JUMP: begin
                    if (moving) begin
                        ctx_n.state = ST_RUN;
                        ctx_n.frame = 3'd0;
                        ctx_n.step  = 8'd0;
                    end else begin
                        ctx_n.state = ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (moving) begin
                        ctx_n.state = ST_RUN;
                        ctx_n.frame = 3'd0;
                        ctx_n.step  = 8'd0;
                        ctx_n.still = 8'd0;
                    end
                end
                ST_RUN: begin
                    if (moving) begin
                        ctx_n.still = 8'd0;
                        if (ctx.step == STEP_LAST) begin
                            ctx_n.step  = 8'd0;
                            ctx_n.frame = (ctx.frame == FRAME_LAST) ? 3'd0 : ctx.frame + 3'd1;
                        end else begin
                            ctx_n.step = ctx.step + 8'd1;
                        end
                    end else if (ctx.still == STILL_LAST) begin
                        // Standing still long enough: drop back to the idle pose.
                        ctx_n.state = ST_IDLE;
                        ctx_n.still = 8'd0;
                        ctx_n.frame = 3'd0;
                    end else begin
                        ctx_n.still = ctx.still + 8'd1;
                    end
                end
                default: ctx_n = CTX_RST;
            endcase
        end
    end

    always_comb begin
        spr_n = {ctx_n.dir,
                 ctx_n.state == ST_JUMP,
                 ctx_n.state == ST_IDLE,
                 (ctx_n.state == ST_RUN) ? {1'b0, ctx_n.frame} : 4'b0000};
    end

    // Output word and change pulse are registered together, so anim_step marks the first cycle of a new value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spr_q  <= SPR_RST;
            step_q <= 1'b0;
        end else if (bus.frame_tick) begin
            spr_q  <= spr_n;
            step_q <= (spr_n != spr_q);
        end else begin
            step_q <= 1'b0;
        end
    end

    assign bus.sprite_control = spr_q;
    assign bus.anim_step      = step_q;
endmodule

// File: tb/tb_sprite_anim_ctl.sv
// Randomized and directed bench for sprite_anim_ctl against a behavioural pose model.
module tb_sprite_anim_ctl;
    localparam int FPS = 4;
    localparam int RF  = 8;
    localparam int IDL = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    sprite_anim_if bus ();

    sprite_anim_ctl #(.FRAMES_PER_STEP(FPS), .RUN_FRAMES(RF), .IDLE_DELAY(IDL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Model state: 0 idle, 1 run, 2 jump.
    int   m_mode, m_pose, m_sub, m_wait;
    logic m_right;
    logic [6:0] m_spr;
    logic m_pulse;

    function automatic logic [6:0] pose_word(int mode, logic right, int pose);
        logic [6:0] w;
        w = {right, 6'b0};
        if (mode == 2) w[5] = 1'b1;
        else if (mode == 0) w[4] = 1'b1;
        else w[2:0] = 3'(pose);
        return w;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = 0; m_right = 1'b1; m_pose = 0; m_sub = 0; m_wait = 0;
            m_spr = 7'h50; m_pulse = 1'b0;
        end else if (bus.frame_tick) begin
            logic mv;
            logic [6:0] prev;
            prev = m_spr;
            mv = bus.move_left != bus.move_right;
            if (mv) m_right = bus.move_right;
            if (bus.airborne) begin
                m_mode = 2; m_pose = 0; m_sub = 0; m_wait = 0;
            end else if (m_mode == 2) begin
                if (mv) begin m_mode = 1; m_pose = 0; m_sub = 0; end
                else m_mode = 0;
            end else if (m_mode == 0) begin
                if (mv) begin m_mode = 1; m_pose = 0; m_sub = 0; m_wait = 0; end
            end else if (mv) begin
                m_wait = 0;
                m_sub = m_sub + 1;
                if (m_sub == FPS) begin m_sub = 0; m_pose = (m_pose + 1) % RF; end
            end else begin
                m_wait = m_wait + 1;
                if (m_wait == IDL) begin m_mode = 0; m_wait = 0; m_pose = 0; end
            end
            m_spr = pose_word(m_mode, m_right, m_pose);
            m_pulse = (m_spr != prev);
        end else begin
            m_pulse = 1'b0;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_sprite", bus.sprite_control, m_spr);
        chk("model_step", bus.anim_step, m_pulse);
    end

    task automatic drive(input logic t, input logic l, input logic r, input logic a);
        @(negedge clk);
        bus.frame_tick = t; bus.move_left = l; bus.move_right = r; bus.airborne = a;
        @(negedge clk);
        bus.frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n, input logic l, input logic r, input logic a);
        for (int i = 0; i < n; i++) drive(1'b1, l, r, a);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.frame_tick = 1'b0; bus.move_left = 1'b0; bus.move_right = 1'b0; bus.airborne = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [6:0] held;
        bus.frame_tick = 1'b0; bus.move_left = 1'b0; bus.move_right = 1'b0; bus.airborne = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_sprite", bus.sprite_control, 7'h50);
        chk("reset_step", bus.anim_step, 0);
        rst = 1'b0;

        // Run right: pose advances every FPS ticks, wraps after 8 poses.
        ticks(1, 1'b0, 1'b1, 1'b0);
        chk("run_first", bus.sprite_control, 7'h40);
        chk("run_first_step", bus.anim_step, 1);
        ticks(1, 1'b0, 1'b1, 1'b0);
        chk("run_hold_step", bus.anim_step, 0);
        ticks(3, 1'b0, 1'b1, 1'b0);
        chk("run_tick5", bus.sprite_control, 7'h41);
        ticks(16, 1'b0, 1'b1, 1'b0);
        chk("run_tick21", bus.sprite_control, 7'h45);
        ticks(8, 1'b0, 1'b1, 1'b0);
        chk("run_tick29", bus.sprite_control, 7'h47);
        ticks(4, 1'b0, 1'b1, 1'b0);
        chk("run_wrap", bus.sprite_control, 7'h40);

        // Async reset mid-cycle while running at frame 5.
        do_reset();
        ticks(21, 1'b0, 1'b1, 1'b0);
        chk("pre_rst_f5", bus.sprite_control, 7'h45);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_sprite", bus.sprite_control, 7'h50);
        chk("async_rst_step", bus.anim_step, 0);
        @(negedge clk);
        rst = 1'b0;

        // Left, then both held: dir kept, idles after IDLE_DELAY.
        ticks(1, 1'b1, 1'b0, 1'b0);
        chk("left_run", bus.sprite_control, 7'h00);
        ticks(1, 1'b1, 1'b1, 1'b0);
        chk("both_still1", bus.sprite_control, 7'h00);
        ticks(1, 1'b1, 1'b1, 1'b0);
        chk("both_idle", bus.sprite_control, 7'h10);

        // Jump and landing.
        do_reset();
        ticks(21, 1'b0, 1'b1, 1'b0);
        ticks(1, 1'b0, 1'b1, 1'b1);
        chk("jump_right", bus.sprite_control, 7'h60);
        ticks(1, 1'b1, 1'b0, 1'b1);
        chk("jump_left", bus.sprite_control, 7'h20);
        ticks(1, 1'b1, 1'b0, 1'b0);
        chk("land_moving", bus.sprite_control, 7'h00);
        ticks(1, 1'b1, 1'b0, 1'b1);
        ticks(1, 1'b0, 1'b0, 1'b0);
        chk("land_still", bus.sprite_control, 7'h10);

        // Release at frame 3, then a re-press clears the still count.
        do_reset();
        ticks(13, 1'b0, 1'b1, 1'b0);
        chk("frame3", bus.sprite_control, 7'h43);
        ticks(1, 1'b0, 1'b0, 1'b0);
        chk("still1_hold", bus.sprite_control, 7'h43);
        ticks(1, 1'b0, 1'b0, 1'b0);
        chk("still2_idle", bus.sprite_control, 7'h50);
        do_reset();
        ticks(13, 1'b0, 1'b1, 1'b0);
        ticks(1, 1'b0, 1'b0, 1'b0);
        ticks(1, 1'b0, 1'b1, 1'b0);
        ticks(1, 1'b0, 1'b0, 1'b0);
        chk("repress_clears", bus.sprite_control, 7'h43);

        // No ticks: inputs toggle freely, outputs hold.
        held = bus.sprite_control;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            bus.frame_tick = 1'b0;
            {bus.move_left, bus.move_right, bus.airborne} = 3'($urandom);
        end
        @(negedge clk);
        chk("no_tick_hold", bus.sprite_control, held);
        chk("no_tick_step", bus.anim_step, 0);

        // Random traffic, back-to-back ticks allowed; the model compare covers every cycle.
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            bus.frame_tick = ($urandom_range(0, 9) < 5);
            if ($urandom_range(0, 15) == 0) begin
                bus.move_left  = ($urandom_range(0, 2) == 0);
                bus.move_right = ($urandom_range(0, 1) == 0);
            end
            if ($urandom_range(0, 15) == 0) bus.airborne = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 1999) == 0) rst = 1'b1;
            else rst = 1'b0;
        end
        @(negedge clk);
        bus.frame_tick = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
